// File: rtl/tpu_apb_pkg.sv
// Shared APB definitions for the cfg-register initiator.
// - APB_ADDR_W / APB_DATA_W : default address/data widths (REG_ADDRWIDTH / REG_DATAWIDTH)
// - apb_state_e             : initiator phase (IDLE / SETUP / ACCESS)
// - apb_cmd_t               : queued command {write, addr, wdata} at default widths
package tpu_apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with registered storage.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata    : write enable / entry to store (caller must not push when full)
//   pop, rdata     : read enable / head entry (valid when !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries
module apb_cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wptr, rptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

endmodule

// File: rtl/apb_cmd_master.sv
// Command-driven APB initiator for the cfg register block.
// Commands are queued in a small FIFO and issued one APB transfer each, in
// order; every command yields exactly one response (rdata + err).
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write/addr/wdata : command push channel
//   rsp_valid/ready, rsp_write/rdata/err  : response channel
//   busy                               : queue non-empty, transfer active, or response pending
//   PADDR/PWRITE/PSEL/PENABLE/PWDATA   : APB requester outputs
//   PRDATA/PREADY                      : APB completer inputs
// Optional: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// PREADY-low cycles (response carries rsp_err=1). Without it rsp_err is 0.
module apb_cmd_master
  import tpu_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH;

  apb_state_e                  state, state_n;
  logic                        push, pop, done, abort;
  logic                        full, empty;
  logic [CW-1:0]               head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // No bypass: a full queue refuses even when it is popped this cycle.
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;

  apb_cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({cmd_write, cmd_addr, cmd_wdata}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset)                          tcnt <= '0;
    else if (pop)                       tcnt <= '0;
    else if (state == ACCESS && !PREADY) tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        // A pending unconsumed response holds off the next transfer.
        if (!empty && (!rsp_valid || rsp_ready)) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          state_n = IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // This low-PREADY cycle would bring the count to the limit.
        else if (tcnt == TMO_LAST) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        PWRITE <= head[CW-1];
        PADDR  <= head[CW-2 -: ADDR_WIDTH];
        PWDATA <= head[DATA_WIDTH-1:0];
      end
      if (done || abort) begin
        rsp_valid <= 1'b1;
        rsp_write <= PWRITE;
        rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
        rsp_err   <= abort;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign busy    = (fifo_count != '0) || (state != IDLE) || rsp_valid;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [7:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE, PREADY;
  logic [31:0] PWDATA, PRDATA;

  int          n_vec = 0;
  int          n_err = 0;

  // Simple completer: PREADY after wait_cfg low ACCESS cycles, or never while hold.
  int          wait_cfg = 0;
  int          acc_cnt  = 0;
  logic        hold     = 1'b0;
  logic        use_addr = 1'b0;
  logic [31:0] prdata_v = '0;

  assign PREADY = !hold && (acc_cnt >= wait_cfg);
  assign PRDATA = use_addr ? {8'hC0, 8'hDE, 8'h00, PADDR} : prdata_v;

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else if (!PENABLE)              acc_cnt <= 0;
  end

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One command through the full pipeline with cycle-exact checks.
  task automatic run_vec(input vec_t v);
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    prdata_v = v.prdata; wait_cfg = v.waits; cmd_valid = 1'b1; rsp_ready = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();                                          // N+1
    cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
    chk("psel_n1", PSEL, 0);
    chk("busy_n1", busy, 1);
    tick();                                          // N+2
    chk("psel_n2", PSEL, 1);
    chk("penable_n2", PENABLE, 0);
    tick();                                          // N+3
    chk("penable_n3", PENABLE, 1);
    chk("paddr", PADDR, v.addr);
    chk("pwrite", PWRITE, v.wr);
    if (v.wr) chk("pwdata", PWDATA, v.wdata);
    for (int k = 0; k < v.waits; k++) begin
      chk("rsp_early", rsp_valid, 0);
      tick();
      chk("penable_wait", PENABLE, 1);
      chk("paddr_stable", PADDR, v.addr);
    end
    chk("rsp_early", rsp_valid, 0);
    tick();                                          // N+4+waits
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_write", rsp_write, v.wr);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, 0);
    chk("psel_after", PSEL, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    vec_t  tv;
    int    got, bad, nrsp, k, n;
    logic  drop;
    logic [11:0] seq;

    vecs[0] = '{wr:1'b1, addr:8'h04, wdata:32'h0000_0001, prdata:32'h1111_1111, waits:0, exp_rdata:32'h0};
    vecs[1] = '{wr:1'b0, addr:8'h10, wdata:32'h0,         prdata:32'hDEAD_BEEF, waits:2, exp_rdata:32'hDEAD_BEEF};
    vecs[2] = '{wr:1'b0, addr:8'hFF, wdata:32'h0,         prdata:32'h1234_5678, waits:0, exp_rdata:32'h1234_5678};
    vecs[3] = '{wr:1'b1, addr:8'h00, wdata:32'hFFFF_FFFF, prdata:32'h5555_5555, waits:1, exp_rdata:32'h0};
    vecs[4] = '{wr:1'b0, addr:8'h80, wdata:32'h0,         prdata:32'h0,         waits:3, exp_rdata:32'h0};
    vecs[5] = '{wr:1'b1, addr:8'hAA, wdata:32'hA5A5_A5A5, prdata:32'h2222_2222, waits:0, exp_rdata:32'h0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    chk("cmd_ready_post_rst", cmd_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stalled response: queue fills, then drains in order.
    use_addr = 1'b1; wait_cfg = 0; rsp_ready = 1'b0; cmd_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_addr = 8'h20 + 8'(i); cmd_valid = 1'b1;
      chk("stall_push_ready", cmd_ready, 1);
      tick();
    end
    cmd_addr = 8'h25;
    for (int i = 0; i < 6; i++) tick();
    chk("stall_full", cmd_ready, 0);
    chk("stall_rsp0_valid", rsp_valid, 1);
    chk("stall_rsp0_data", rsp_rdata, 32'hC0DE_0020);
    chk("stall_no_psel", PSEL, 0);
    rsp_ready = 1'b1; got = 0; drop = 1'b0;
    for (int g = 0; g < 80 && got < 6; g++) begin
      if (cmd_valid && cmd_ready) drop = 1'b1;
      if (rsp_valid) begin
        chk("stall_order", rsp_rdata, {24'hC0DE00, 8'h20 + 8'(got)});
        got++;
      end
      tick();
      if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
    end
    cmd_valid = 1'b0;
    chk("stall_rsp_count", got, 6);
    tick(); tick(); tick(); tick();
    chk("stall_busy_end", busy, 0);
    use_addr = 1'b0;

    // Back-to-back writes: PSEL 1,1,0 repeating.
    rsp_ready = 1'b1; seq = '0; k = 0; nrsp = 0;
    for (int c = 0; c < 14; c++) begin
      if (c >= 2) seq = {seq[10:0], PSEL};
      if (PSEL && !PENABLE) begin
        chk("b2b_pwdata", PWDATA, 32'h1000_0000 + k);
        k++;
      end
      if (rsp_valid) nrsp++;
      if (c < 4) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'(c); cmd_wdata = 32'h1000_0000 + c;
      end else cmd_valid = 1'b0;
      tick();
    end
    chk("b2b_psel_pattern", {20'h0, seq}, {20'h0, 12'b110110110110});
    chk("b2b_rsp_count", nrsp, 4);

    // Reset during ACCESS with two commands still queued.
    hold = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30 + 8'(c); cmd_wdata = 32'hABCD_0000 + c;
      end else cmd_valid = 1'b0;
      if (c < 4) tick();
    end
    chk("mid_penable", PENABLE, 1);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0; hold = 1'b0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (PSEL || rsp_valid || busy) bad++;
      tick();
    end
    chk("mid_no_activity", bad, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout abort after 8 low-PREADY ACCESS cycles.
    hold = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; prdata_v = 32'h7777_7777;
    tick();
    cmd_valid = 1'b0; n = 0;
    for (int g = 0; g < 40; g++) begin
      if (PENABLE) n++;
      else if (n > 0) break;
      tick();
    end
    chk("tmo_access_cycles", n, 8);
    chk("tmo_psel", PSEL, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; hold = 1'b0;
    // PREADY on the limit cycle completes normally.
    tv = '{wr:1'b0, addr:8'h44, wdata:32'h0, prdata:32'hCAFE_F00D, waits:7, exp_rdata:32'hCAFE_F00D};
    run_vec(tv);
`else
    chk("no_tmo_err", rsp_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
